fc_layer_seq: RTL

//  Parametrised, signed fully-connected layer: out[o] = sat(sum_i in[i]*w[o][i] + b[o]).

---
 rtl/fc_layer_seq_if.sv | 27 ++
 rtl/fc_layer_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fc_layer_seq_if.sv
// Bundles the request/operand/result signals of fc_layer_seq.
// The master side issues start with operands; the slave side returns scores and status.
interface fc_layer_seq_if #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8
);
  // start is a one-cycle request honoured only while busy is low; done pulses once per accepted request.
  logic                            start;
  logic [N_IN*DATA_W-1:0]          in_flat;
  logic [N_OUT*N_IN*DATA_W-1:0]    weights_flat;
  logic [N_OUT*DATA_W-1:0]         bias_flat;
  logic [N_OUT*DATA_W-1:0]         out_flat;
  logic                            busy;
  logic                            done;
  logic [1:0]                      state;

  modport master (
    output start, in_flat, weights_flat, bias_flat,
    input  out_flat, busy, done, state
  );

  modport slave (
    input  start, in_flat, weights_flat, bias_flat,
    output out_flat, busy, done, state
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Signed fully-connected layer with one shared MAC, walking N_OUT x N_IN sequentially.
// Optional macro FC_RELU_EN fuses a ReLU after saturation in the write-back step.
module fc_layer_seq #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  fc_layer_seq_if.slave bus
);
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN) + 1;
  localparam int I_W   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int O_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q;
  logic [I_W-1:0]             i_q;
  logic [O_W-1:0]             o_q;
  logic [N_OUT*DATA_W-1:0]    out_q;
  logic                       done_q;

  logic signed [DATA_W-1:0]   in_q  [N_IN];
  logic signed [DATA_W-1:0]   w_q   [N_OUT][N_IN];
  logic signed [DATA_W-1:0]   b_q   [N_OUT];
  logic signed [DATA_W-1:0]   res_q [N_OUT];

  logic                       accept;
  logic                       last_i, last_o;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_next, sum;
  logic signed [ACC_W-1:0]    max_v, min_v;
  logic signed [DATA_W-1:0]   sat_v, res_v;
  logic [N_OUT*DATA_W-1:0]    res_flat;

  assign accept = (state_q == IDLE) && bus.start;
  assign last_i = (i_q == I_W'(N_IN - 1));
  assign last_o = (o_q == O_W'(N_OUT - 1));

  // Datapath: one product per MAC cycle, bias add plus clamp in WB.
  always_comb begin
    prod     = in_q[i_q] * w_q[o_q][i_q];
    acc_next = acc_q + ACC_W'(prod);
    sum      = acc_q + ACC_W'(b_q[o_q]);
    max_v    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    min_v    = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (sum > max_v)      sat_v = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sum < min_v) sat_v = {1'b1, {(DATA_W-1){1'b0}}};
    else                  sat_v = sum[DATA_W-1:0];
`ifdef FC_RELU_EN
    res_v = sat_v[DATA_W-1] ? '0 : sat_v;
`else
    res_v = sat_v;
`endif
  end

  always_comb begin
    res_flat = '0;
    for (int o = 0; o < N_OUT; o++) res_flat[o*DATA_W +: DATA_W] = res_q[o];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (last_i)    state_d = WB;
      WB:      state_d = last_o ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      o_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          acc_q <= '0;
          i_q   <= '0;
          o_q   <= '0;
        end
        MAC: begin
          acc_q <= acc_next;
          i_q   <= last_i ? '0 : i_q + 1'b1;
        end
        WB: begin
          acc_q <= '0;
          if (!last_o) o_q <= o_q + 1'b1;
        end
        DONE: begin
          out_q  <= res_flat;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand snapshot and result slots carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_IN; i++) in_q[i] <= bus.in_flat[i*DATA_W +: DATA_W];
      for (int o = 0; o < N_OUT; o++) begin
        b_q[o] <= bus.bias_flat[o*DATA_W +: DATA_W];
        for (int i = 0; i < N_IN; i++)
          w_q[o][i] <= bus.weights_flat[(o*N_IN+i)*DATA_W +: DATA_W];
      end
    end
    if (state_q == WB) res_q[o_q] <= res_v;
  end

  assign bus.out_flat = out_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;
endmodule
